ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SYS_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 TIMEOUT_US, default 200, maximum allowed gap between PS/2 clock falling edges inside one frame, in microseconds.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
REQ-006 ps2_data  in  1  raw keyboard data, asynchronous to clk.
REQ-007 key_valid  out  1  one-cycle pulse marking a completed key event.
REQ-008 key_code  out  8  scan code of the last event, held until the next event.
REQ-009 key_ext  out  1  last event carried an E0 prefix; held with key_code.
REQ-010 key_release  out  1  last event carried an F0 prefix (break code); held with key_code.
REQ-011 frame_err  out  1  one-cycle pulse on a discarded frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge is synced-previous 1 and synced-current 0.
REQ-013 Data SHALL be sampled from the synchronised ps2_data in the cycle the falling edge is detected.
REQ-014 FSM states: IDLE, RECV, DONE.
- IDLE: an edge with data 0 (start bit) -> RECV, bit count 0; an edge with data 1 is ignored.
- RECV: 8 data bits LSB first, then the parity bit, then the stop bit; the stop-bit edge -> DONE.
- DONE: evaluates the frame for one cycle, then -> IDLE.
REQ-015 Frame check in DONE: stop bit 1 and odd parity over data plus parity bit (see REQ-025); on failure pulse frame_err, clear both prefix flags, emit no event.
REQ-016 Timeout: cycle limit = SYS_FREQ/1_000_000*TIMEOUT_US; the counter clears on every falling edge and counts only in RECV; on reaching limit-1 -> IDLE, pulse frame_err, clear the prefix flags.
REQ-017 A falling edge in the same cycle as timeout expiry SHALL win: the counter clears and no timeout occurs.
REQ-018 A valid byte 0xE0 SHALL set the ext flag; 0xF0 SHALL set the brk flag; neither produces an event.
REQ-019 A valid byte 0x00 or 0xFF (keyboard overrun) SHALL clear both flags and produce no event or frame_err.
REQ-020 Any other valid byte SHALL, in the cycle after DONE:
- pulse key_valid;
- load key_code = byte, key_ext = ext flag, key_release = brk flag;
- clear both flags.
REQ-021 Latency from detection of the stop-bit falling edge to key_valid SHALL be exactly 2 clk cycles.
REQ-022 key_valid and frame_err SHALL never be high in the same cycle, and neither SHALL stay high longer than one cycle.

Reset
REQ-023 While sys_rst is high at a clk edge: FSM -> IDLE; bit count, shift register, timeout counter, prefix flags, synchronisers (to 1) cleared; key_valid, frame_err, key_ext, key_release = 0; key_code = 0x00.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no frame_err; decoding SHALL resume at the next start bit after release.

Configuration
REQ-025 Macro PS2_PARITY_CHECK_EN:
- Defined: odd-parity failure is a frame error per REQ-015.
- Undefined: the parity bit is received but ignored; only the stop bit and timeout cause frame_err.

Verification
REQ-026 Frame 0x1C with good parity and stop -> key_valid once 2 cycles after the stop edge; key_code=0x1C, key_ext=0, key_release=0.
REQ-027 Frames F0,1C -> a single key_valid, key_code=0x1C, key_release=1, key_ext=0; a following frame 1C -> key_release=0.
REQ-028 Frames E0,F0,75 -> a single key_valid, key_code=0x75, key_ext=1, key_release=1.
REQ-029 Frame 0x1C with the parity bit flipped, macro defined -> frame_err pulse and no key_valid; same stimulus, macro undefined -> key_valid with key_code=0x1C.
REQ-030 Start plus 5 bits, then ps2_clk held high for 250 us -> exactly one frame_err at the 200 us limit; the next good frame 0x29 decodes normally.
REQ-031 sys_rst pulsed after 4 bits of a frame -> all outputs 0 and no frame_err; the next frame 0x5A -> key_valid with key_code=0x5A.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-side lines and decoded key-event outputs of ps2_key_decoder.
// slave: decoder side; master: keyboard/consumer side (testbench).
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;

    modport slave (
        input  ps2_clk, ps2_data,
        output key_valid, key_code, key_ext, key_release, frame_err
    );
    modport master (
        output ps2_clk, ps2_data,
        input  key_valid, key_code, key_ext, key_release, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder (E0 extended / F0 break prefixes).
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
    parameter int SYS_FREQ   = 100_000_000,
    parameter int TIMEOUT_US = 200
) (
    input  logic              clk,
    input  logic              sys_rst,
    ps2_key_decoder_if.slave  bus
);
    localparam int LIMIT = SYS_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int CW    = $clog2(LIMIT + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    logic [1:0]    r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par, r_stop;
    logic [CW-1:0] r_to_cnt;
    logic          r_ext, r_brk;
    logic          r_key_valid, r_key_ext, r_key_release, r_frame_err;
    logic [7:0]    r_key_code;

    logic w_fall, w_data, w_frame_ok;

    assign w_fall     = r_clk_prev & ~r_clk_sync[1];
    assign w_data     = r_dat_sync[1];
    // With parity checking disabled the parity bit is still shifted in but never judged.
    assign w_frame_ok = r_stop & (~PAR_EN | (^{r_shift, r_par}));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_clk_sync    <= 2'b11;
            r_dat_sync    <= 2'b11;
            r_clk_prev    <= 1'b1;
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_stop        <= 1'b0;
            r_to_cnt      <= '0;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_key_valid   <= 1'b0;
            r_key_code    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_release <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], bus.ps2_data};
            r_clk_prev  <= r_clk_sync[1];
            r_key_valid <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_fall && !w_data) begin
                        r_state   <= S_RECV;
                        r_bit_cnt <= '0;
                    end
                end
                S_RECV: begin
                    // A clock edge coinciding with expiry takes priority over the timeout.
                    if (w_fall) begin
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < 4'd8) begin
                            r_shift <= {w_data, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            r_par <= w_data;
                        end else begin
                            r_stop  <= w_data;
                            r_state <= S_DONE;
                        end
                    end else if (r_to_cnt == CW'(LIMIT - 1)) begin
                        r_state     <= S_IDLE;
                        r_frame_err <= 1'b1;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_IDLE;
                    if (!w_frame_ok) begin
                        r_frame_err <= 1'b1;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                    end else begin
                        case (r_shift)
                            8'hE0: r_ext <= 1'b1;
                            8'hF0: r_brk <= 1'b1;
                            8'h00, 8'hFF: begin
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                            end
                            default: begin
                                r_key_valid   <= 1'b1;
                                r_key_code    <= r_shift;
                                r_key_ext     <= r_ext;
                                r_key_release <= r_brk;
                                r_ext         <= 1'b0;
                                r_brk         <= 1'b0;
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_valid   = r_key_valid;
    assign bus.key_code    = r_key_code;
    assign bus.key_ext     = r_key_ext;
    assign bus.key_release = r_key_release;
    assign bus.frame_err   = r_frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, expected events queued
// by the driver and popped by an independent output monitor.
module tb_ps2_key_decoder;
    localparam int SYS_FREQ   = 10_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int LIMIT      = SYS_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int HALF       = 20;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         rel;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    ps2_key_decoder_if bus();

    ps2_key_decoder #(.SYS_FREQ(SYS_FREQ), .TIMEOUT_US(TIMEOUT_US)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t ek(input logic [7:0] code, input bit ext, input bit rel);
        exp_t e;
        e.err = 1'b0; e.code = code; e.ext = ext; e.rel = rel; e.cyc = -1;
        return e;
    endfunction

    function automatic exp_t ee();
        exp_t e;
        e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.rel = 1'b0; e.cyc = -1;
        return e;
    endfunction

    task automatic ps2_bit(input logic d, output int fall_cyc);
        bus.ps2_data = d;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // Result of a complete frame appears 4 cycles after the stop-bit clock drop:
    // 2 synchroniser stages, DONE, then the registered output.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                              input bit push, input exp_t e);
        int   fc;
        logic par;
        exp_t x;
        par = ~(^b) ^ flip_par;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
        ps2_bit(par, fc);
        bus.ps2_data = ~bad_stop;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b0;
        if (push) begin
            x = e;
            x.cyc = cyc + 4;
            q.push_back(x);
        end
        wait_cyc(HALF);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_key_valid"},   32'(bus.key_valid),   32'd0);
        chk({tag, "_frame_err"},   32'(bus.frame_err),   32'd0);
        chk({tag, "_key_code"},    32'(bus.key_code),    32'd0);
        chk({tag, "_key_ext"},     32'(bus.key_ext),     32'd0);
        chk({tag, "_key_release"}, 32'(bus.key_release), 32'd0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard queue.
    bit prev_pulse = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.key_valid === 1'b1 && bus.frame_err === 1'b1) begin
                checks++; errors++;
                $display("FAIL both_pulses: key_valid and frame_err high together at cycle %0d", cyc);
            end
            if (bus.key_valid === 1'b1 || bus.frame_err === 1'b1) begin
                if (prev_pulse) begin
                    checks++; errors++;
                    $display("FAIL pulse_width: output pulse longer than one cycle at cycle %0d", cyc);
                end
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: kv=%0b fe=%0b code=%0h with nothing expected, cycle %0d",
                             bus.key_valid, bus.frame_err, bus.key_code, cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_is_err", 32'(bus.frame_err), 32'(e.err));
                    if (!e.err) begin
                        chk("key_code",    32'(bus.key_code),    32'(e.code));
                        chk("key_ext",     32'(bus.key_ext),     32'(e.ext));
                        chk("key_release", 32'(bus.key_release), 32'(e.rel));
                    end
                    if (e.cyc >= 0) chk("event_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_pulse = (bus.key_valid === 1'b1) || (bus.frame_err === 1'b1);
        end
    end

    initial begin
        int   fc;
        exp_t e;
        logic [7:0] pb;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        sys_rst      = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        sys_rst = 1'b0;
        wait_cyc(10);

        // Plain make code
        send_frame(8'h1C, 0, 0, 1, ek(8'h1C, 0, 0));
        // Break code, then make code with release cleared
        send_frame(8'hF0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'h1C, 0, 0, 1, ek(8'h1C, 0, 1));
        send_frame(8'h1C, 0, 0, 1, ek(8'h1C, 0, 0));
        // Extended break
        send_frame(8'hE0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'hF0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'h75, 0, 0, 1, ek(8'h75, 1, 1));
        // Flipped parity
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h1C, 1, 0, 1, ee());
`else
        send_frame(8'h1C, 1, 0, 1, ek(8'h1C, 0, 0));
`endif
        // Bad stop bit clears a pending prefix
        send_frame(8'hE0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'h1C, 0, 1, 1, ee());
        send_frame(8'h6B, 0, 0, 1, ek(8'h6B, 0, 0));
        // Overrun byte clears prefixes silently
        send_frame(8'hE0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'hF0, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'h00, 0, 0, 0, ek(8'h00, 0, 0));
        send_frame(8'h4A, 0, 0, 1, ek(8'h4A, 0, 0));
        send_frame(8'hFF, 0, 0, 0, ek(8'h00, 0, 0));

        // Timeout: start + 5 data bits, then clock idles for 250 us
        pb = 8'h1C;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 5; i++) ps2_bit(pb[i], fc);
        e = ee();
        e.cyc = fc + 3 + LIMIT;
        q.push_back(e);
        bus.ps2_data = 1'b1;
        wait_cyc(SYS_FREQ / 1_000_000 * 250);
        send_frame(8'h29, 0, 0, 1, ek(8'h29, 0, 0));

        // Reset mid-frame
        pb = 8'h77;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) ps2_bit(pb[i], fc);
        bus.ps2_data = 1'b1;
        sys_rst = 1'b1;
        wait_cyc(2);
        check_outputs_zero("midreset");
        sys_rst = 1'b0;
        wait_cyc(LIMIT + 500);
        send_frame(8'h5A, 0, 0, 1, ek(8'h5A, 0, 0));

        wait_cyc(50);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
